decoder_pipe_n: RTL

//  Parametrised successor to the 1-2 / 2-4 decoder tree: SEL_W-bit index -> 2**SEL_W one-hot.

---
 rtl/decoder_pipe_n_if.sv | 37 +++
 rtl/decoder_pipe_n.sv | 93 +++++++++
 2 files changed

// File: rtl/decoder_pipe_n_if.sv
// Write-back decode bus: index request in, one-hot write-enable vector and bookkeeping out.
interface decoder_pipe_n_if #(
    parameter int unsigned SEL_W = 5
);
    localparam int unsigned N = 1 << SEL_W;

    logic             enable;
    logic [SEL_W-1:0] input_select;
    logic             flush;
    logic             clear_written;
    logic [N-1:0]     output_select;
    logic             output_valid;
    logic [N-1:0]     written_map;
    logic [SEL_W-1:0] last_select;

    modport master (
        output enable,
        output input_select,
        output flush,
        output clear_written,
        input  output_select,
        input  output_valid,
        input  written_map,
        input  last_select
    );

    modport slave (
        input  enable,
        input  input_select,
        input  flush,
        input  clear_written,
        output output_select,
        output output_valid,
        output written_map,
        output last_select
    );
endinterface

// File: rtl/decoder_pipe_n.sv
// Pipelined SEL_W -> 2**SEL_W one-hot decoder with zero-register masking, flush,
// sticky written bitmap and last-written index tracking.
module decoder_pipe_n #(
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned PIPE      = 1,
    parameter int unsigned ZERO_IDX  = 31,
    parameter int unsigned MASK_ZERO = 1
) (
    input logic              clk,
    input logic              reset_n,
    decoder_pipe_n_if.slave  bus
);
    localparam int unsigned N = 1 << SEL_W;
    localparam logic [SEL_W-1:0] ZeroSel = SEL_W'(ZERO_IDX);

    if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
        $error("decoder_pipe_n: SEL_W must be in 1..6");
    end
    if (PIPE > 3) begin : g_bad_pipe
        $error("decoder_pipe_n: PIPE must be in 0..3");
    end
    if (ZERO_IDX >= N) begin : g_bad_zero_idx
        $error("decoder_pipe_n: ZERO_IDX must be below 2**SEL_W");
    end

    logic [N-1:0]     dec;
    logic             zero_hit;
    logic [N-1:0]     sel_out;
    logic [SEL_W-1:0] sel_enc;
    logic [N-1:0]     written_q;
    logic [SEL_W-1:0] last_sel_q;

    always_comb begin
        zero_hit = (MASK_ZERO != 0) && (bus.input_select == ZeroSel);
        dec      = '0;
        if (bus.enable && !zero_hit) begin
            dec[bus.input_select] = 1'b1;
        end
    end

    if (PIPE == 0) begin : g_comb
        assign sel_out = bus.flush ? '0 : dec;
    end else begin : g_pipe
        logic [N-1:0] stage_q [PIPE];

        // Flush clears the capture stage too, so the input seen during flush is dropped.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < PIPE; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (bus.flush) begin
                for (int unsigned i = 0; i < PIPE; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= dec;
                for (int unsigned i = 1; i < PIPE; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign sel_out = stage_q[PIPE-1];
    end

    always_comb begin
        sel_enc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_out[i]) begin
                sel_enc = SEL_W'(i);
            end
        end
    end

    // A clear coinciding with an output keeps that output's bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            written_q  <= '0;
            last_sel_q <= '0;
        end else begin
            written_q <= bus.clear_written ? sel_out : (written_q | sel_out);
            if (sel_out != '0) begin
                last_sel_q <= sel_enc;
            end
        end
    end

    assign bus.output_select = sel_out;
    assign bus.output_valid  = |sel_out;
    assign bus.written_map   = written_q;
    assign bus.last_select   = last_sel_q;
endmodule
